// File: rtl/pipe_control_pkg.sv
// Shared definitions for the pipeline control block.
// Holds the controller state encoding and the default bubble word.
package pipe_control_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } pipe_state_t;

    localparam logic [31:0] BUBBLE_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/pipe_control.sv
// Pipeline controller: steps, stalls, kills and drains a two-slot
// execute/writeback pipeline, with debug halt/resume and a retire count.
module pipe_control
    import pipe_control_pkg::*;
#(
    parameter bit          RESET_HALTED       = 1'b0,
    parameter logic [31:0] BUBBLE_INSTRUCTION = BUBBLE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetchValid,
    input  logic [31:0] fetchInstruction,
    output logic        fetchRequest,
    input  logic        memoryBusy,
    input  logic        jumpTaken,
    input  logic        haltRequest,
    input  logic        resumeRequest,
    output logic        halted,
    output logic        stepPipe,
    output logic        fetchStall,
    output logic        executeStall,
    output logic        writebackStall,
    output logic [31:0] stageInstruction,
    output logic [31:0] instructionsRetired
);

    pipe_state_t state;
    logic        exec_valid;
    logic        wb_valid;
    logic [31:0] retire_count;

    localparam pipe_state_t RESET_STATE = RESET_HALTED ? HALTED : RUN;

    // Combinational pipeline handshakes derived from state and inputs.
    always_comb begin
        fetchRequest     = (state == RUN) && !haltRequest;
        stepPipe         = !memoryBusy &&
                           (((state == RUN) && fetchValid) ||
                            (state == DRAIN));
        fetchStall       = !((state == RUN) && fetchValid && !jumpTaken);
        executeStall     = !exec_valid;
        writebackStall   = !wb_valid;
        stageInstruction = fetchStall ? BUBBLE_INSTRUCTION
                                      : fetchInstruction;
        instructionsRetired = retire_count;
    end

    // Run/drain/halt sequencing with a registered halted flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RESET_STATE;
            halted <= RESET_HALTED;
        end else begin
            unique case (state)
                RUN: begin
                    if (haltRequest) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!exec_valid && !wb_valid) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end
                end
                HALTED: begin
                    if (resumeRequest && !haltRequest) begin
                        state  <= RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= RESET_STATE;
                    halted <= RESET_HALTED;
                end
            endcase
        end
    end

    // Slot valid bits and retire counter advance only on a step.
    always_ff @(posedge clk) begin
        if (rst) begin
            exec_valid   <= 1'b0;
            wb_valid     <= 1'b0;
            retire_count <= 32'd0;
        end else if (stepPipe) begin
            exec_valid <= !fetchStall;
            wb_valid   <= exec_valid;
            if (wb_valid) begin
                retire_count <= retire_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_control.sv
// Scoreboard bench for pipe_control: a directed vector table feeds the
// DUT and queues hand-computed responses; a monitor pops and compares.
module tb_pipe_control;

    logic        clk;
    logic        rst;
    logic        fetchValid;
    logic [31:0] fetchInstruction;
    logic        fetchRequest;
    logic        memoryBusy;
    logic        jumpTaken;
    logic        haltRequest;
    logic        resumeRequest;
    logic        halted;
    logic        stepPipe;
    logic        fetchStall;
    logic        executeStall;
    logic        writebackStall;
    logic [31:0] stageInstruction;
    logic [31:0] instructionsRetired;

    pipe_control #(
        .RESET_HALTED(1'b1),
        .BUBBLE_INSTRUCTION(32'hFFFF_FFFF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fetchValid(fetchValid),
        .fetchInstruction(fetchInstruction),
        .fetchRequest(fetchRequest),
        .memoryBusy(memoryBusy),
        .jumpTaken(jumpTaken),
        .haltRequest(haltRequest),
        .resumeRequest(resumeRequest),
        .halted(halted),
        .stepPipe(stepPipe),
        .fetchStall(fetchStall),
        .executeStall(executeStall),
        .writebackStall(writebackStall),
        .stageInstruction(stageInstruction),
        .instructionsRetired(instructionsRetired)
    );

    localparam logic [31:0] B = 32'hFFFF_FFFF;

    typedef struct {
        string       name;
        logic        rst;
        logic        fv;
        logic [31:0] fi;
        logic        mb;
        logic        jt;
        logic        hr;
        logic        rr;
        logic [5:0]  flags;
        logic [31:0] si;
        logic [31:0] cnt;
    } vec_t;

    typedef struct {
        string       name;
        logic [5:0]  flags;
        logic [31:0] si;
        logic [31:0] cnt;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    bit   stim_done = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flags = {fetchRequest, stepPipe, fetchStall,
    //          executeStall, writebackStall, halted}
    task automatic add(input string n, input logic r, input logic fv,
                       input logic [31:0] fi, input logic mb,
                       input logic jt, input logic hr, input logic rr,
                       input logic [5:0] f, input logic [31:0] si,
                       input logic [31:0] cnt);
        vec_t v;
        v.name = n; v.rst = r; v.fv = fv; v.fi = fi; v.mb = mb;
        v.jt = jt; v.hr = hr; v.rr = rr; v.flags = f; v.si = si;
        v.cnt = cnt;
        vecs.push_back(v);
    endtask

    initial begin
        //   name            rst fv fi      mb jt hr rr flags       si       cnt
        add("reset_state",   0, 0, 32'd0,  0, 0, 0, 0, 6'b001111, B,       0);
        add("halt_and_res",  0, 0, 32'd0,  0, 0, 1, 1, 6'b001111, B,       0);
        add("still_halted",  0, 0, 32'd0,  0, 0, 0, 0, 6'b001111, B,       0);
        add("resume",        0, 0, 32'd0,  0, 0, 0, 1, 6'b001111, B,       0);
        add("run_idle",      0, 0, 32'd0,  0, 0, 0, 0, 6'b101110, B,       0);
        add("instr1",        0, 1, 32'd1,  0, 0, 0, 0, 6'b110110, 32'd1,   0);
        add("instr2",        0, 1, 32'd2,  0, 0, 0, 0, 6'b110010, 32'd2,   0);
        add("instr3",        0, 1, 32'd3,  0, 0, 0, 0, 6'b110000, 32'd3,   0);
        add("busy1",         0, 1, 32'd4,  1, 0, 0, 0, 6'b100000, 32'd4,   1);
        add("busy2",         0, 1, 32'd4,  1, 0, 0, 0, 6'b100000, 32'd4,   1);
        add("busy3",         0, 1, 32'd4,  1, 0, 0, 0, 6'b100000, 32'd4,   1);
        add("busy4",         0, 1, 32'd4,  1, 0, 0, 0, 6'b100000, 32'd4,   1);
        add("instr4",        0, 1, 32'd4,  0, 0, 0, 0, 6'b110000, 32'd4,   1);
        add("jump_kill",     0, 1, 32'h13, 0, 1, 0, 0, 6'b111000, B,       2);
        add("after_jump",    0, 0, 32'd0,  0, 0, 0, 1, 6'b101100, B,       3);
        add("instr5",        0, 1, 32'd5,  0, 0, 0, 0, 6'b110100, 32'd5,   3);
        add("bubble_nocnt",  0, 1, 32'd6,  0, 0, 0, 0, 6'b110010, 32'd6,   4);
        add("halt_req",      0, 0, 32'd0,  0, 0, 1, 0, 6'b001000, B,       4);
        add("drain1",        0, 0, 32'd0,  0, 0, 0, 0, 6'b011000, B,       4);
        add("drain2",        0, 0, 32'd0,  0, 0, 0, 1, 6'b011100, B,       5);
        add("drain3",        0, 0, 32'd0,  0, 0, 0, 0, 6'b011110, B,       6);
        add("halted_after",  0, 0, 32'd0,  0, 0, 0, 0, 6'b001111, B,       6);
        add("resume2",       0, 0, 32'd0,  0, 0, 0, 1, 6'b001111, B,       6);
        add("fill1",         0, 1, 32'd7,  0, 0, 0, 0, 6'b110110, 32'd7,   6);
        add("fill2",         0, 1, 32'd8,  0, 0, 0, 0, 6'b110010, 32'd8,   6);
        add("halt_req2",     0, 0, 32'd0,  0, 0, 1, 0, 6'b001000, B,       6);
        add("drain_busy",    0, 0, 32'd0,  1, 0, 0, 0, 6'b001000, B,       6);
        add("rst_in_drain",  1, 0, 32'd0,  1, 0, 0, 0, 6'b001000, B,       6);
        add("post_reset",    0, 0, 32'd0,  0, 0, 0, 0, 6'b001111, B,       0);
    end

    // Stimulus: reset, then one vector per cycle, pushing expectations.
    initial begin
        rst = 1'b1;
        fetchValid = 1'b0;
        fetchInstruction = 32'd0;
        memoryBusy = 1'b0;
        jumpTaken = 1'b0;
        haltRequest = 1'b0;
        resumeRequest = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        foreach (vecs[i]) begin
            exp_t e;
            #1;
            rst              = vecs[i].rst;
            fetchValid       = vecs[i].fv;
            fetchInstruction = vecs[i].fi;
            memoryBusy       = vecs[i].mb;
            jumpTaken        = vecs[i].jt;
            haltRequest      = vecs[i].hr;
            resumeRequest    = vecs[i].rr;
            e.name  = vecs[i].name;
            e.flags = vecs[i].flags;
            e.si    = vecs[i].si;
            e.cnt   = vecs[i].cnt;
            sb.push_back(e);
            @(posedge clk);
        end
        stim_done = 1'b1;
    end

    // Monitor: pop one expectation per presented cycle and compare.
    initial begin
        int idle;
        exp_t e;
        logic [5:0] af;
        idle = 0;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                af = {fetchRequest, stepPipe, fetchStall,
                      executeStall, writebackStall, halted};
                checks++;
                if (af !== e.flags || stageInstruction !== e.si ||
                    instructionsRetired !== e.cnt) begin
                    failures++;
                    $display("FAIL %s: got flags=%b instr=%h retired=%0d, expected flags=%b instr=%h retired=%0d",
                             e.name, af, stageInstruction,
                             instructionsRetired, e.flags, e.si, e.cnt);
                end
            end else if (stim_done) begin
                break;
            end else begin
                idle++;
                if (idle > 1000) begin
                    failures++;
                    $display("FAIL timeout: stimulus did not finish");
                    break;
                end
            end
        end
        if (checks != vecs.size()) begin
            failures++;
            $display("FAIL check_count: got %0d, expected %0d",
                     checks, vecs.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
